// File: rtl/ram_nport_if.sv
// Bus bundle for ram_nport: read ports, write port and clear control.
// The master drives requests; the slave (the RAM) returns read data, valids and busy.
interface ram_nport_if #(
    parameter int unsigned ADDR_WIDTH = 3,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned NUM_READ   = 2
);
    logic [NUM_READ-1:0]            r_en;
    logic [NUM_READ*ADDR_WIDTH-1:0] r_addr;
    logic [NUM_READ*DATA_WIDTH-1:0] r_data;
    logic [NUM_READ-1:0]            r_valid;
    logic                           write_enable;
    logic [ADDR_WIDTH-1:0]          w_addr;
    logic [DATA_WIDTH-1:0]          w_data;
    logic                           clear_req;
    logic                           busy;

    modport master (
        output r_en, r_addr, write_enable, w_addr, w_data, clear_req,
        input  r_data, r_valid, busy
    );

    modport slave (
        input  r_en, r_addr, write_enable, w_addr, w_data, clear_req,
        output r_data, r_valid, busy
    );
endinterface

// File: rtl/ram_nport.sv
// N-read-port, single-write-port RAM with registered reads and a clear sweep.
// After reset or on clear_req every entry is overwritten with CLEAR_VALUE, one per
// cycle; user accesses are ignored while the sweep runs (busy=1).
// Optional macro RAM_NPORT_BYPASS_EN: write-first read/write collision behaviour.
// Without it, a read of the address being written returns the old contents.
module ram_nport #(
    parameter int unsigned           ADDR_WIDTH  = 3,
    parameter int unsigned           DATA_WIDTH  = 8,
    parameter int unsigned           NUM_READ    = 2,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
    input logic         clk_i,
    input logic         rst_i,
    ram_nport_if.slave  bus
);
    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(DEPTH - 1);

    localparam logic [0:0] StClear = 1'b0;
    localparam logic [0:0] StReady = 1'b1;

    logic [0:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] r_data_q [NUM_READ];
    logic [NUM_READ-1:0]   r_valid_q;
    logic [DATA_WIDTH-1:0] rd_word [NUM_READ];
    logic                  ready;

    assign ready = (state_q == StReady);

    // Sweep sequencer: walk cnt through every entry, then hand over to user traffic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == StClear) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LastAddr) begin
                state_d = StReady;
            end
        end else if (bus.clear_req) begin
            state_d = StClear;
            cnt_d   = '0;
        end
    end

    // Sequencer state; reset always restarts a full sweep from entry 0.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StClear;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Storage: the sweep owns the write port while clearing; no reset on the array.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (state_q == StClear) begin
                mem_q[cnt_q] <= CLEAR_VALUE;
            end else if (bus.write_enable) begin
                mem_q[bus.w_addr] <= bus.w_data;
            end
        end
    end

    // Per-port read word, including the same-cycle write forwarding when enabled.
    always_comb begin
        for (int unsigned i = 0; i < NUM_READ; i++) begin
            rd_word[i] = mem_q[bus.r_addr[i*ADDR_WIDTH +: ADDR_WIDTH]];
`ifdef RAM_NPORT_BYPASS_EN
            if (bus.write_enable && (bus.w_addr == bus.r_addr[i*ADDR_WIDTH +: ADDR_WIDTH])) begin
                rd_word[i] = bus.w_data;
            end
`endif
        end
    end

    // Registered read ports: data updates only on an accepted read, otherwise holds.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_valid_q <= '0;
            for (int unsigned i = 0; i < NUM_READ; i++) begin
                r_data_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_READ; i++) begin
                if (ready && bus.r_en[i]) begin
                    r_valid_q[i] <= 1'b1;
                    r_data_q[i]  <= rd_word[i];
                end else begin
                    r_valid_q[i] <= 1'b0;
                end
            end
        end
    end

    // Pack the per-port registers onto the bus.
    always_comb begin
        bus.r_data = '0;
        for (int unsigned i = 0; i < NUM_READ; i++) begin
            bus.r_data[i*DATA_WIDTH +: DATA_WIDTH] = r_data_q[i];
        end
    end

    assign bus.r_valid = r_valid_q;
    assign bus.busy    = (state_q == StClear);
endmodule

// File: tb/tb_ram_nport.sv
// Bench for ram_nport: two instances (CLEAR_VALUE 8'h00 and 8'hFF) driven by identical
// stimulus. A behavioural model predicts each cycle's outputs; predictions are queued
// before the clock edge and popped/compared after it.
module tb_ram_nport;
`ifdef RAM_NPORT_BYPASS_EN
    localparam bit Bypass = 1'b1;
`else
    localparam bit Bypass = 1'b0;
`endif

    typedef struct packed {
        logic            busy;
        logic [1:0]      valid0;
        logic [1:0]      valid1;
        logic [3:0][7:0] d;      // index u*2+port
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] r_en;
    logic [5:0] r_addr;
    logic       we;
    logic [2:0] w_addr;
    logic [7:0] w_data;
    logic       clear_req;

    ram_nport_if #(.ADDR_WIDTH(3), .DATA_WIDTH(8), .NUM_READ(2)) if0 ();
    ram_nport_if #(.ADDR_WIDTH(3), .DATA_WIDTH(8), .NUM_READ(2)) if1 ();

    assign if0.r_en = r_en;         assign if1.r_en = r_en;
    assign if0.r_addr = r_addr;     assign if1.r_addr = r_addr;
    assign if0.write_enable = we;   assign if1.write_enable = we;
    assign if0.w_addr = w_addr;     assign if1.w_addr = w_addr;
    assign if0.w_data = w_data;     assign if1.w_data = w_data;
    assign if0.clear_req = clear_req;
    assign if1.clear_req = clear_req;

    ram_nport #(.ADDR_WIDTH(3), .DATA_WIDTH(8), .NUM_READ(2), .CLEAR_VALUE(8'h00)) u_dut0 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (if0.slave)
    );

    ram_nport #(.ADDR_WIDTH(3), .DATA_WIDTH(8), .NUM_READ(2), .CLEAR_VALUE(8'hFF)) u_dut1 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (if1.slave)
    );

    always #5 clk = ~clk;

    // Model state
    logic [7:0] mdl_mem [2][8];
    logic [7:0] mdl_rd  [2][2];
    logic [1:0] mdl_valid;
    logic       mdl_clearing;
    int         mdl_cnt;
    exp_t       sb [$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the current inputs.
    task automatic model_edge();
        logic [7:0] clr [2];
        clr[0] = 8'h00;
        clr[1] = 8'hFF;
        if (rst) begin
            mdl_valid    = 2'b00;
            mdl_clearing = 1'b1;
            mdl_cnt      = 0;
            for (int u = 0; u < 2; u++) begin
                for (int i = 0; i < 2; i++) mdl_rd[u][i] = 8'h00;
            end
        end else if (mdl_clearing) begin
            mdl_valid = 2'b00;
            for (int u = 0; u < 2; u++) mdl_mem[u][mdl_cnt] = clr[u];
            if (mdl_cnt == 7) begin
                mdl_clearing = 1'b0;
                mdl_cnt      = 0;
            end else begin
                mdl_cnt++;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                logic [2:0] a;
                a = r_addr[i*3 +: 3];
                mdl_valid[i] = r_en[i];
                if (r_en[i]) begin
                    for (int u = 0; u < 2; u++) begin
                        if (Bypass && we && (w_addr == a)) mdl_rd[u][i] = w_data;
                        else mdl_rd[u][i] = mdl_mem[u][a];
                    end
                end
            end
            if (we) begin
                for (int u = 0; u < 2; u++) mdl_mem[u][w_addr] = w_data;
            end
            if (clear_req) begin
                mdl_clearing = 1'b1;
                mdl_cnt      = 0;
            end
        end
    endtask

    task automatic step();
        exp_t e;
        exp_t g;
        model_edge();
        e.busy   = mdl_clearing;
        e.valid0 = mdl_valid;
        e.valid1 = mdl_valid;
        for (int u = 0; u < 2; u++) begin
            for (int i = 0; i < 2; i++) e.d[u*2+i] = mdl_rd[u][i];
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        g = sb.pop_front();
        check("busy0", 32'(if0.busy), 32'(g.busy));
        check("busy1", 32'(if1.busy), 32'(g.busy));
        check("valid0", 32'(if0.r_valid), 32'(g.valid0));
        check("valid1", 32'(if1.r_valid), 32'(g.valid1));
        check("d0_p0", 32'(if0.r_data[7:0]), 32'(g.d[0]));
        check("d0_p1", 32'(if0.r_data[15:8]), 32'(g.d[1]));
        check("d1_p0", 32'(if1.r_data[7:0]), 32'(g.d[2]));
        check("d1_p1", 32'(if1.r_data[15:8]), 32'(g.d[3]));
    endtask

    task automatic idle();
        r_en = 2'b00; we = 1'b0; clear_req = 1'b0;
    endtask

    task automatic rd(input logic [1:0] en, input logic [2:0] a0, input logic [2:0] a1);
        r_en = en; r_addr = {a1, a0};
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        we = 1'b1; w_addr = a; w_data = d;
    endtask

    // Count consecutive busy observations (starting now), bounded.
    task automatic count_busy(input string tag, input logic [1:0] en);
        int bc;
        bc = 0;
        for (int k = 0; k < 20; k++) begin
            if (!if0.busy) break;
            bc++;
            rd(en, 3'(k), 3'(7 - k));
            step();
        end
        check(tag, 32'(bc), 32'd8);
        idle();
    endtask

    initial begin
        for (int u = 0; u < 2; u++) begin
            for (int a = 0; a < 8; a++) mdl_mem[u][a] = 8'h00;
        end
        idle();
        r_addr = '0; w_addr = '0; w_data = '0;

        // 1: reset, sweep length, cleared contents
        rst = 1'b1;
        step();
        rst = 1'b0;
        count_busy("busy_len_reset", 2'b00);
        for (int a = 0; a < 8; a++) begin
            rd(2'b11, 3'(a), 3'(7 - a));
            step();
        end
        idle(); step();

        // 2: two writes then dual read
        wr(3'd3, 8'hA5); step();
        wr(3'd6, 8'h5A); step();
        idle(); rd(2'b11, 3'd3, 3'd6); step();
        idle(); step();

        // 3: read/write collision, then re-read
        wr(3'd2, 8'h3C); rd(2'b01, 3'd2, 3'd0); step();
        idle(); rd(2'b01, 3'd2, 3'd0); step();
        idle(); step();

        // 4: fill, clear, write and re-request during sweep are dropped
        for (int a = 0; a < 8; a++) begin
            wr(3'(a), 8'(8'h10 + a)); step();
        end
        idle(); clear_req = 1'b1; step();
        clear_req = 1'b1; wr(3'd1, 8'h11); step();
        clear_req = 1'b0; we = 1'b0;
        begin
            int bc;
            bc = 2;
            for (int k = 0; k < 20; k++) begin
                if (!if0.busy) break;
                bc++;
                step();
            end
            check("busy_len_clear", 32'(bc), 32'd9);
        end
        for (int a = 0; a < 8; a++) begin
            rd(2'b11, 3'(a), 3'(a)); step();
        end
        idle(); step();

        // 5: reset mid-sweep restarts the full sweep; reads ignored while busy
        clear_req = 1'b1; step();
        clear_req = 1'b0;
        for (int k = 0; k < 4; k++) begin
            rd(2'b11, 3'(k), 3'(k)); step();
        end
        rst = 1'b1; step();
        rst = 1'b0;
        count_busy("busy_len_midrst", 2'b11);

        // 6: both ports on the same entry, then single-port read holds the other
        wr(3'd7, 8'h77); step();
        idle(); rd(2'b11, 3'd7, 3'd7); step();
        rd(2'b01, 3'd0, 3'd7); step();
        idle(); step();

        // Random traffic
        for (int k = 0; k < 40; k++) begin
            r_en = 2'($urandom_range(0, 3));
            r_addr = 6'($urandom);
            we = 1'($urandom);
            w_addr = 3'($urandom);
            w_data = 8'($urandom);
            clear_req = ($urandom_range(0, 15) == 0);
            step();
        end
        idle();
        for (int k = 0; k < 10; k++) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
